// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Register-file write port arbiter; the pipeline has priority and
//            auxiliary results are queued with squash and starvation stall.
// Revision : 1.0
// ============================================================================
module wb_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_WIDTH    = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                 i_Clock,
    input  logic                                 i_Reset,
    input  logic [DATA_WIDTH-1:0]                i_PipeWrData,
    input  logic [REG_WIDTH-1:0]                 i_PipeWrAddr,
    input  logic                                 i_PipeWrEnable,
    input  logic                                 i_AuxValid,
    input  logic [DATA_WIDTH-1:0]                i_AuxData,
    input  logic [REG_WIDTH-1:0]                 i_AuxAddr,
    output logic                                 o_AuxReady,
    output logic                                 o_PipeStall,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      o_AuxCount,
    output logic [DATA_WIDTH-1:0]                o_RegWrData,
    output logic [REG_WIDTH-1:0]                 o_RegWrAddr,
    output logic                                 o_RegWrEnable
);

    localparam int c_CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0]    c_DEPTH = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_STARVE_W-1:0] c_LIMIT = c_STARVE_W'(STARVE_LIMIT);

    logic [DATA_WIDTH-1:0] r_data_mem [FIFO_DEPTH];
    logic [REG_WIDTH-1:0]  r_addr_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_kill;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_STARVE_W-1:0] r_starve;
    logic                  r_stall;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [REG_WIDTH-1:0]  r_wr_addr;
    logic                  r_wr_en;

    logic w_pipe_valid;
    logic w_not_empty;
    logic w_ready;
    logic w_push;
    logic w_pop;

    // Writes to x0 are architecturally void, so they never claim the port.
    assign w_pipe_valid = i_PipeWrEnable && (i_PipeWrAddr != '0);
    assign w_not_empty  = (r_count != '0);
    assign w_ready      = !i_Reset && (r_count < c_DEPTH);
    assign w_push       = i_AuxValid && w_ready && (i_AuxAddr != '0);
    assign w_pop        = !w_pipe_valid && w_not_empty;

    always_ff @(posedge i_Clock) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= i_AuxData;
            r_addr_mem[r_wr_ptr] <= i_AuxAddr;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_kill    <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_stall   <= 1'b0;
            r_wr_data <= '0;
            r_wr_addr <= '0;
            r_wr_en   <= 1'b0;
        end else begin
            // A newer pipeline write makes any queued result to the same register stale.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (w_pipe_valid && (r_addr_mem[i] == i_PipeWrAddr)) begin
                    r_kill[i] <= 1'b1;
                end
            end
            if (w_push) begin
                r_kill[r_wr_ptr] <= 1'b0;
                r_wr_ptr         <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

            if (!w_not_empty || w_pop) begin
                r_starve <= '0;
            end else if (r_starve != c_LIMIT) begin
                r_starve <= r_starve + c_STARVE_W'(1);
            end
            r_stall <= w_not_empty && !w_pop && (r_starve == c_LIMIT);

            if (w_pipe_valid) begin
                r_wr_en   <= 1'b1;
                r_wr_data <= i_PipeWrData;
                r_wr_addr <= i_PipeWrAddr;
            end else if (w_pop) begin
                r_wr_en   <= !r_kill[r_rd_ptr];
                r_wr_data <= r_data_mem[r_rd_ptr];
                r_wr_addr <= r_addr_mem[r_rd_ptr];
            end else begin
                r_wr_en   <= 1'b0;
            end
        end
    end

    assign o_AuxReady    = w_ready;
    assign o_PipeStall   = r_stall;
    assign o_AuxCount    = r_count;
    assign o_RegWrData   = r_wr_data;
    assign o_RegWrAddr   = r_wr_addr;
    assign o_RegWrEnable = r_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pipe_data;
    logic [RW-1:0] pipe_addr;
    logic          pipe_en;
    logic          aux_valid;
    logic [DW-1:0] aux_data;
    logic [RW-1:0] aux_addr;
    logic          aux_ready;
    logic          pipe_stall;
    logic [1:0]    aux_count;
    logic [DW-1:0] wr_data;
    logic [RW-1:0] wr_addr;
    logic          wr_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [RW-1:0] addr;
        logic [DW-1:0] data;
        bit            kill;
    } entry_t;

    entry_t mq[$];
    int     m_starve;
    bit     m_stall;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_WIDTH  (DW),
        .REG_WIDTH   (RW),
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_PipeWrData  (pipe_data),
        .i_PipeWrAddr  (pipe_addr),
        .i_PipeWrEnable(pipe_en),
        .i_AuxValid    (aux_valid),
        .i_AuxData     (aux_data),
        .i_AuxAddr     (aux_addr),
        .o_AuxReady    (aux_ready),
        .o_PipeStall   (pipe_stall),
        .o_AuxCount    (aux_count),
        .o_RegWrData   (wr_data),
        .o_RegWrAddr   (wr_addr),
        .o_RegWrEnable (wr_en)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic en, input logic [RW-1:0] a, input logic [DW-1:0] d);
        pipe_en = en; pipe_addr = a; pipe_data = d;
    endtask

    task automatic set_aux(input logic v, input logic [RW-1:0] a, input logic [DW-1:0] d);
        aux_valid = v; aux_addr = a; aux_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_pipe(0, 0, 0); set_aux(0, 0, 0);
        tick(); tick();
        checks++; if (aux_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", aux_ready); end
        checks++; if ({wr_en, wr_data, wr_addr} !== '0) begin errors++; $display("FAIL reset_wr: got en=%b d=%h a=%0d expected zeros", wr_en, wr_data, wr_addr); end
        checks++; if (pipe_stall !== 1'b0 || aux_count !== 2'd0) begin errors++; $display("FAIL reset_state: got stall=%b cnt=%0d expected 0/0", pipe_stall, aux_count); end
        rst = 1'b0;
        #1;
        checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", aux_ready); end
    endtask

    task automatic test_pipe_only();
        set_pipe(1, 5, 32'h11); tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'h11}) begin errors++; $display("FAIL pipe_x5: got en=%b a=%0d d=%h expected 1/5/11", wr_en, wr_addr, wr_data); end
        set_pipe(1, 6, 32'h22); tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd6, 32'h22}) begin errors++; $display("FAIL pipe_x6: got en=%b a=%0d d=%h expected 1/6/22", wr_en, wr_addr, wr_data); end
        set_pipe(1, 0, 32'h33); tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== {1'b0, 5'd6, 32'h22}) begin errors++; $display("FAIL pipe_x0: got en=%b a=%0d d=%h expected 0/6/22 held", wr_en, wr_addr, wr_data); end
        set_pipe(0, 0, 0);
    endtask

    task automatic test_aux_drain();
        set_aux(1, 7, 32'hABCD); tick();
        checks++; if (aux_count !== 2'd1 || wr_en !== 1'b0) begin errors++; $display("FAIL drain_push: got cnt=%0d en=%b expected 1/0", aux_count, wr_en); end
        set_aux(0, 0, 0); tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd7, 32'hABCD} || aux_count !== 2'd0) begin
            errors++; $display("FAIL drain_pop: got en=%b a=%0d d=%h cnt=%0d expected 1/7/abcd/0", wr_en, wr_addr, wr_data, aux_count);
        end
    endtask

    task automatic test_full_queue();
        set_pipe(1, 1, 32'h100); set_aux(1, 10, 32'hA); tick();
        set_pipe(1, 1, 32'h101); set_aux(1, 11, 32'hB); tick();
        set_pipe(1, 1, 32'h102); set_aux(1, 12, 32'hC); #1;
        checks++; if (aux_ready !== 1'b0 || aux_count !== 2'd2) begin errors++; $display("FAIL full_ready: got rdy=%b cnt=%0d expected 0/2", aux_ready, aux_count); end
        tick();
        checks++; if (aux_count !== 2'd2) begin errors++; $display("FAIL full_hold: got cnt=%0d expected 2", aux_count); end
        set_pipe(0, 0, 0); tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd10, 32'hA} || aux_count !== 2'd1) begin
            errors++; $display("FAIL full_pop1: got en=%b a=%0d d=%h cnt=%0d expected 1/10/a/1", wr_en, wr_addr, wr_data, aux_count);
        end
        tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd11, 32'hB} || aux_count !== 2'd1) begin
            errors++; $display("FAIL full_pushpop: got en=%b a=%0d d=%h cnt=%0d expected 1/11/b/1", wr_en, wr_addr, wr_data, aux_count);
        end
        set_aux(0, 0, 0); tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd12, 32'hC} || aux_count !== 2'd0) begin
            errors++; $display("FAIL full_pop3: got en=%b a=%0d d=%h cnt=%0d expected 1/12/c/0", wr_en, wr_addr, wr_data, aux_count);
        end
    endtask

    task automatic test_starvation();
        set_pipe(1, 1, 32'h200); set_aux(1, 8, 32'h55); tick();
        set_aux(0, 0, 0);
        for (int i = 0; i < LIMIT; i++) begin
            tick();
            checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_early%0d: got %b expected 0", i, pipe_stall); end
        end
        tick();
        checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL starve_stall: got %b expected 1", pipe_stall); end
        tick();
        checks++; if (pipe_stall !== 1'b1 || wr_addr !== 5'd1) begin errors++; $display("FAIL starve_violate: got stall=%b a=%0d expected 1/1", pipe_stall, wr_addr); end
        set_pipe(0, 0, 0); tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd8, 32'h55} || pipe_stall !== 1'b0) begin
            errors++; $display("FAIL starve_release: got en=%b a=%0d d=%h stall=%b expected 1/8/55/0", wr_en, wr_addr, wr_data, pipe_stall);
        end
    endtask

    task automatic test_squash();
        set_pipe(1, 1, 32'h300); set_aux(1, 9, 32'h1); tick();
        set_pipe(1, 9, 32'h2); set_aux(0, 0, 0); tick();
        checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd9, 32'h2}) begin errors++; $display("FAIL squash_pipe: got en=%b a=%0d d=%h expected 1/9/2", wr_en, wr_addr, wr_data); end
        set_pipe(0, 0, 0); tick();
        checks++; if (wr_en !== 1'b0 || aux_count !== 2'd0) begin errors++; $display("FAIL squash_pop: got en=%b cnt=%0d expected 0/0", wr_en, aux_count); end
    endtask

    task automatic test_reset_mid();
        set_pipe(1, 1, 32'h400); set_aux(1, 3, 32'h33); tick();
        set_aux(1, 4, 32'h44); tick();
        set_aux(0, 0, 0); set_pipe(0, 0, 0); rst = 1'b1; #1;
        checks++; if (aux_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", aux_ready); end
        tick();
        checks++; if (aux_count !== 2'd0 || {wr_en, wr_data, wr_addr} !== '0 || pipe_stall !== 1'b0) begin
            errors++; $display("FAIL midrst_state: got cnt=%0d en=%b d=%h a=%0d stall=%b expected zeros", aux_count, wr_en, wr_data, wr_addr, pipe_stall);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL midrst_nowrite%0d: got %b expected 0", i, wr_en); end
        end
    endtask

    task automatic test_random();
        bit            exp_en;
        logic [DW-1:0] exp_data;
        logic [RW-1:0] exp_addr;
        bit            exp_ready, pv, popped;
        int            old_size;
        entry_t        h;
        rst = 1'b1; set_pipe(0, 0, 0); set_aux(0, 0, 0); tick();
        mq.delete(); m_starve = 0; m_stall = 0;
        for (int c = 0; c < 1000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            pipe_en   = ($urandom_range(0, 99) < (m_stall ? 10 : 55));
            pipe_addr = RW'($urandom_range(0, 7));
            pipe_data = $urandom;
            aux_valid = $urandom_range(0, 1) == 1;
            aux_addr  = RW'($urandom_range(0, 7));
            aux_data  = $urandom;
            #1;
            exp_ready = !rst && (mq.size() < DEPTH);
            checks++; if (aux_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", c, aux_ready, exp_ready); end
            exp_en = 0; exp_data = '0; exp_addr = '0;
            if (rst) begin
                mq.delete(); m_starve = 0; m_stall = 0;
            end else begin
                pv       = pipe_en && pipe_addr != 0;
                old_size = mq.size();
                popped   = !pv && old_size > 0;
                if (pv) begin
                    foreach (mq[i]) if (mq[i].addr == pipe_addr) mq[i].kill = 1;
                    exp_en = 1; exp_data = pipe_data; exp_addr = pipe_addr;
                end else if (popped) begin
                    h = mq.pop_front();
                    exp_en = !h.kill; exp_data = h.data; exp_addr = h.addr;
                end
                // Stall follows one cycle behind a saturated blocked run.
                m_stall  = old_size > 0 && !popped && m_starve == LIMIT;
                m_starve = (old_size == 0 || popped) ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
                if (exp_ready && aux_valid && aux_addr != 0) mq.push_back('{aux_addr, aux_data, 1'b0});
            end
            tick();
            checks++; if (wr_en !== exp_en) begin errors++; $display("FAIL rand_en c%0d: got %b expected %b", c, wr_en, exp_en); end
            if (exp_en) begin
                checks++; if (wr_data !== exp_data || wr_addr !== exp_addr) begin
                    errors++; $display("FAIL rand_wr c%0d: got a=%0d d=%h expected a=%0d d=%h", c, wr_addr, wr_data, exp_addr, exp_data);
                end
            end
            checks++; if (aux_count !== 2'(mq.size())) begin errors++; $display("FAIL rand_count c%0d: got %0d expected %0d", c, aux_count, mq.size()); end
            checks++; if (pipe_stall !== m_stall) begin errors++; $display("FAIL rand_stall c%0d: got %b expected %b", c, pipe_stall, m_stall); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_aux_drain();
        test_full_queue();
        test_starvation();
        test_squash();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
